// File: rtl/pwr_seq_ctrl_pkg.sv
// pwr_seq_ctrl_pkg
// Shared definitions for the power-rail sequencer: FSM state encoding
// (3-bit binary) and default timing constants for a 25 MHz SYSCLK.
package pwr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ON_WAIT  = 3'd1,
    ST_ON_GAP   = 3'd2,
    ST_RUN      = 3'd3,
    ST_OFF_STEP = 3'd4,
    ST_OFF_GAP  = 3'd5,
    ST_FAULT    = 3'd6
  } seq_state_e;

  localparam int          DEF_NUM_RAIL   = 4;
  localparam logic [15:0] DEF_PG_TIMEOUT = 16'd50000;  // 2 ms
  localparam logic [15:0] DEF_STEP_GAP   = 16'd2500;   // 100 us
  localparam logic [15:0] DEF_OFF_GAP    = 16'd2500;   // 100 us

endpackage

// File: rtl/pwr_seq_ctrl_sync2.sv
// sync2
// Parameterized-width two-flop synchronizer, async active-low reset to 0.
// Ports:
//   SYSCLK   in        destination clock
//   RESET_N  in        async reset, active-low
//   d_i      in  WIDTH asynchronous input
//   q_o      out WIDTH synchronized output
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             SYSCLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl
// Power-rail sequencer. Enables rails in ascending order, waiting for each
// rail's power-good (with timeout) plus a settle gap before the next one;
// disables in descending order with a gap between rails. A PG timeout or a
// PG loss on an enabled rail drops every enable and latches a one-hot fault map.
// Ports:
//   SYSCLK      in            system clock (25 MHz)
//   RESET_N     in            async reset, active-low
//   PWR_ON_REQ  in            level request, 1 = power up, 0 = down / clear fault
//   PG_IN       in  NUM_RAIL  per-rail power-good (asynchronous)
//   EN_OUT      out NUM_RAIL  per-rail enable (registered)
//   SEQ_DONE    out           all rails enabled and good
//   SEQ_FAULT   out           fault latched
//   FAULT_MAP   out NUM_RAIL  one-hot rail that caused the fault
//
// state    | meaning
// IDLE     | all rails off, waiting for request
// ON_WAIT  | rail IDX enabled, waiting for its PG (timeout counted in CNT)
// ON_GAP   | rail IDX good, settling STEP_GAP cycles before the next rail
// RUN      | all rails enabled and good
// OFF_STEP | rail IDX disabled this step
// OFF_GAP  | waiting OFF_GAP cycles before disabling rail IDX-1
// FAULT    | all rails off, fault map held until request drops
module pwr_seq_ctrl
  import pwr_seq_ctrl_pkg::*;
#(
  parameter int          NUM_RAIL   = DEF_NUM_RAIL,
  parameter logic [15:0] PG_TIMEOUT = DEF_PG_TIMEOUT,
  parameter logic [15:0] STEP_GAP   = DEF_STEP_GAP,
  parameter logic [15:0] OFF_GAP    = DEF_OFF_GAP
) (
  input  logic                SYSCLK,
  input  logic                RESET_N,
  input  logic                PWR_ON_REQ,
  input  logic [NUM_RAIL-1:0] PG_IN,
  output logic [NUM_RAIL-1:0] EN_OUT,
  output logic                SEQ_DONE,
  output logic                SEQ_FAULT,
  output logic [NUM_RAIL-1:0] FAULT_MAP
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_RAIL - 1);

  logic                req_s;
  logic [NUM_RAIL-1:0] pg_s;

  seq_state_e          state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [NUM_RAIL-1:0] en_q, en_d;
  logic                done_q, done_d;
  logic                flt_q, flt_d;
  logic [NUM_RAIL-1:0] map_q, map_d;

  logic [NUM_RAIL-1:0] chk_mask;
  logic [NUM_RAIL-1:0] loss_map;
  logic [NUM_RAIL-1:0] idx_hot;
  logic                loss;
  logic                pg_cur;

  sync2 #(.WIDTH(1)) u_sync_req (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .d_i     (PWR_ON_REQ),
    .q_o     (req_s)
  );

  sync2 #(.WIDTH(NUM_RAIL)) u_sync_pg (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .d_i     (PG_IN),
    .q_o     (pg_s)
  );

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
      flt_q   <= 1'b0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      done_q  <= done_d;
      flt_q   <= flt_d;
      map_q   <= map_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    map_d    = map_q;
    en_d     = '0;
    chk_mask = '0;
    loss_map = '0;
    idx_hot  = '0;
    loss     = 1'b0;
    pg_cur   = 1'b0;

    for (int j = 0; j < NUM_RAIL; j++) begin
      idx_hot[j] = (j == int'(idx_q));
      if (j == int'(idx_q)) pg_cur = pg_s[j];
    end

    // Rails that must already be good; the rail awaited in ON_WAIT is excluded.
    case (state_q)
      ST_ON_WAIT: for (int j = 0; j < NUM_RAIL; j++) chk_mask[j] = (j < int'(idx_q));
      ST_ON_GAP:  for (int j = 0; j < NUM_RAIL; j++) chk_mask[j] = (j <= int'(idx_q));
      ST_RUN:     chk_mask = '1;
      default:    chk_mask = '0;
    endcase

    // Descending scan so the lowest failing rail is the one reported.
    for (int j = NUM_RAIL - 1; j >= 0; j--) begin
      if (chk_mask[j] && !pg_s[j]) begin
        loss     = 1'b1;
        loss_map = '0;
        loss_map[j] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_ON_WAIT;
        end
      end
      ST_ON_WAIT: begin
        if (loss) begin
          map_d   = loss_map;
          state_d = ST_FAULT;
        end else if (!req_s) begin
          state_d = ST_OFF_STEP;  // IDX is already the highest enabled rail
        end else if (pg_cur) begin
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? ST_RUN : ST_ON_GAP;
        end else if (cnt_q == PG_TIMEOUT - 16'd1) begin
          map_d   = idx_hot;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ON_GAP: begin
        if (loss) begin
          map_d   = loss_map;
          state_d = ST_FAULT;
        end else if (!req_s) begin
          state_d = ST_OFF_STEP;
        end else if (cnt_q == STEP_GAP - 16'd1) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = ST_ON_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (loss) begin
          map_d   = loss_map;
          state_d = ST_FAULT;
        end else if (!req_s) begin
          idx_d   = LAST_IDX;
          state_d = ST_OFF_STEP;
        end
      end
      ST_OFF_STEP: begin
        cnt_d   = '0;
        state_d = (idx_q == 3'd0) ? ST_IDLE : ST_OFF_GAP;
      end
      ST_OFF_GAP: begin
        if (cnt_q == OFF_GAP - 16'd1) begin
          idx_d   = idx_q - 3'd1;
          state_d = ST_OFF_STEP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_FAULT: begin
        if (!req_s) begin
          map_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_q)
      ST_ON_WAIT, ST_ON_GAP:
        for (int j = 0; j < NUM_RAIL; j++) en_d[j] = (j <= int'(idx_q));
      ST_RUN:
        en_d = '1;
      ST_OFF_STEP, ST_OFF_GAP:
        for (int j = 0; j < NUM_RAIL; j++) en_d[j] = (j < int'(idx_q));
      default:
        en_d = '0;
    endcase

    done_d = (state_q == ST_RUN);
    // Asserts the cycle after FAULT entry, drops together with FAULT_MAP on exit.
    flt_d  = (state_q == ST_FAULT) && (state_d == ST_FAULT);
  end

  assign EN_OUT    = en_q;
  assign SEQ_DONE  = done_q;
  assign SEQ_FAULT = flt_q;
  assign FAULT_MAP = map_q;

endmodule
